// File: rtl/mul_result_stage_pkg.sv
// Multiply result stage shared types.
// State encoding and default datapath width.
package mul_result_stage_pkg;
  localparam int WORD_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_t;
endpackage

// File: rtl/mul_result_stage_reg_w.sv
// Word register with synchronous clear
// and load enable.
module reg_w #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WORD_SIZE-1:0] d,
  output logic [WORD_SIZE-1:0] q
);
  // clear wins over load
  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end
endmodule

// File: rtl/mul_result_stage.sv
// Holds a Booth product and writes it back
// as LO then HI over the CPU bus.
module mul_result_stage
  import mul_result_stage_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   prod_valid,
  output logic                   prod_ready,
  input  logic [2*WORD_SIZE-1:0] prod_data,
  input  logic                   wb_start,
  output logic [WORD_SIZE-1:0]   bus_out,
  output logic                   bus_en,
  output logic [WORD_SIZE-1:0]   hi_out,
  output logic [WORD_SIZE-1:0]   lo_out,
  output logic                   busy,
  output logic                   done
);
  state_t state, state_nx;
  logic   cap_en, lo_en, hi_en;
  logic [WORD_SIZE-1:0] zhi, zlo;

  // state register
  always_ff @(posedge clk) begin
    if (clr)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // done marks the first IDLE cycle after WR_HI
  always_ff @(posedge clk) begin
    if (clr)
      done <= 1'b0;
    else
      done <= (state == WR_HI);
  end

  // next state, enables and bus mux
  always_comb begin
    state_nx   = state;
    cap_en     = 1'b0;
    lo_en      = 1'b0;
    hi_en      = 1'b0;
    bus_out    = '0;
    bus_en     = 1'b0;
    prod_ready = 1'b0;
    unique case (state)
      IDLE: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          cap_en   = 1'b1;
          state_nx = FULL;
        end
      end
      FULL: begin
        if (wb_start)
          state_nx = WR_LO;
      end
      WR_LO: begin
        bus_out  = zlo;
        bus_en   = 1'b1;
        lo_en    = 1'b1;
        state_nx = WR_HI;
      end
      WR_HI: begin
        bus_out  = zhi;
        bus_en   = 1'b1;
        hi_en    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  reg_w #(.WORD_SIZE(WORD_SIZE)) u_zhi (
    .clk (clk),
    .clr (clr),
    .en  (cap_en),
    .d   (prod_data[2*WORD_SIZE-1:WORD_SIZE]),
    .q   (zhi)
  );

  reg_w #(.WORD_SIZE(WORD_SIZE)) u_zlo (
    .clk (clk),
    .clr (clr),
    .en  (cap_en),
    .d   (prod_data[WORD_SIZE-1:0]),
    .q   (zlo)
  );

  reg_w #(.WORD_SIZE(WORD_SIZE)) u_hi (
    .clk (clk),
    .clr (clr),
    .en  (hi_en),
    .d   (zhi),
    .q   (hi_out)
  );

  reg_w #(.WORD_SIZE(WORD_SIZE)) u_lo (
    .clk (clk),
    .clr (clr),
    .en  (lo_en),
    .d   (zlo),
    .q   (lo_out)
  );
endmodule

// File: tb/tb_mul_result_stage.sv
// Self-checking bench for mul_result_stage:
// directed table, hold sequence, random vs model.
module tb_mul_result_stage;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr, prod_valid, wb_start;
  logic [2*W-1:0] prod_data;
  logic          prod_ready, bus_en, busy, done;
  logic [W-1:0]  bus_out, hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_result_stage #(.WORD_SIZE(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .wb_start   (wb_start),
    .bus_out    (bus_out),
    .bus_en     (bus_en),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic           c, pv, ws;
    logic [2*W-1:0] d;
    logic           rdy, bsy, en;
    logic [W-1:0]   bus, hi, lo;
    logic           dn;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic c, pv, ws,
                     input logic [2*W-1:0] d,
                     input logic rdy, bsy, en,
                     input logic [W-1:0] bus, hi, lo,
                     input logic dn);
    vec_t v;
    v.c = c; v.pv = pv; v.ws = ws; v.d = d;
    v.rdy = rdy; v.bsy = bsy; v.en = en;
    v.bus = bus; v.hi = hi; v.lo = lo; v.dn = dn;
    tbl.push_back(v);
  endtask

  task automatic chk_out(input string tag,
                         input logic rdy, bsy, en,
                         input logic [W-1:0] bus, hi, lo,
                         input logic dn);
    chk({tag, ".ready"}, 64'(prod_ready), 64'(rdy));
    chk({tag, ".busy"},  64'(busy),       64'(bsy));
    chk({tag, ".bus_en"},64'(bus_en),     64'(en));
    chk({tag, ".bus"},   64'(bus_out),    64'(bus));
    chk({tag, ".hi"},    64'(hi_out),     64'(hi));
    chk({tag, ".lo"},    64'(lo_out),     64'(lo));
    chk({tag, ".done"},  64'(done),       64'(dn));
  endtask

  // behavioural model: a held product plus a
  // queue of words still to appear on the bus
  logic          m_have, m_dn;
  logic [W-1:0]  m_zhi, m_zlo, m_hi, m_lo;
  logic [W-1:0]  m_q[$];

  task automatic m_edge(input logic c, pv, ws,
                        input logic [2*W-1:0] d);
    if (c) begin
      m_have = 0; m_q.delete();
      m_zhi = 0; m_zlo = 0;
      m_hi = 0; m_lo = 0; m_dn = 0;
    end else begin
      m_dn = 0;
      if (m_q.size() > 0) begin
        if (m_q.size() == 2) m_lo = m_q[0];
        else begin
          m_hi = m_q[0];
          m_dn = 1;
        end
        void'(m_q.pop_front());
      end else if (m_have) begin
        if (ws) begin
          m_q.push_back(m_zlo);
          m_q.push_back(m_zhi);
          m_have = 0;
        end
      end else if (pv) begin
        m_zhi = d[2*W-1:W];
        m_zlo = d[W-1:0];
        m_have = 1;
      end
    end
  endtask

  localparam logic [63:0] P1 = 64'hFFFFFFFF_FFFFFFD6;
  localparam logic [63:0] PA = 64'h0000000A_0000000B;
  localparam logic [63:0] P5 = 64'h00000005_00000006;
  localparam logic [63:0] P7 = 64'h00000007_00000008;

  initial begin
    clr = 1; prod_valid = 0; wb_start = 0;
    prod_data = '0;

    // c pv ws data | rdy bsy en bus hi lo done
    add(1,0,0,0,  1,0,0,0,0,0,0);
    add(0,1,0,P1, 0,1,0,0,0,0,0);
    add(0,0,1,0,  0,1,1,32'hFFFFFFD6,0,0,0);
    add(0,0,0,0,  0,1,1,32'hFFFFFFFF,0,32'hFFFFFFD6,0);
    add(0,0,0,0,  1,0,0,0,32'hFFFFFFFF,32'hFFFFFFD6,1);
    add(0,0,0,0,  1,0,0,0,32'hFFFFFFFF,32'hFFFFFFD6,0);
    add(0,1,1,PA, 0,1,0,0,32'hFFFFFFFF,32'hFFFFFFD6,0);
    add(0,0,0,0,  0,1,0,0,32'hFFFFFFFF,32'hFFFFFFD6,0);
    add(0,0,1,0,  0,1,1,32'hB,32'hFFFFFFFF,32'hFFFFFFD6,0);
    add(0,0,0,0,  0,1,1,32'hA,32'hFFFFFFFF,32'hB,0);
    add(0,0,0,0,  1,0,0,0,32'hA,32'hB,1);
    add(0,1,0,P5, 0,1,0,0,32'hA,32'hB,0);
    add(0,0,1,0,  0,1,1,32'h6,32'hA,32'hB,0);
    add(0,0,0,0,  0,1,1,32'h5,32'hA,32'h6,0);
    add(0,0,0,0,  1,0,0,0,32'h5,32'h6,1);
    add(0,1,0,P7, 0,1,0,0,32'h5,32'h6,0);
    add(0,0,1,0,  0,1,1,32'h8,32'h5,32'h6,0);
    add(0,0,0,0,  0,1,1,32'h7,32'h5,32'h8,0);
    add(1,0,0,0,  1,0,0,0,0,0,0);
    add(0,0,0,0,  1,0,0,0,0,0,0);
    add(0,0,0,0,  1,0,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      clr = tbl[i].c;
      prod_valid = tbl[i].pv;
      wb_start = tbl[i].ws;
      prod_data = tbl[i].d;
      cyc();
      chk_out($sformatf("tbl%0d", i),
              tbl[i].rdy, tbl[i].bsy, tbl[i].en,
              tbl[i].bus, tbl[i].hi, tbl[i].lo,
              tbl[i].dn);
    end

    // hold: product stays put while FULL
    clr = 1; prod_valid = 0; wb_start = 0;
    cyc();
    clr = 0; prod_valid = 1;
    prod_data = 64'h00000001_00000000;
    cyc();
    prod_valid = 0;
    for (int i = 0; i < 10; i++) begin
      prod_valid = (i >= 5);
      if (i >= 5) prod_data = 64'h12345678_9ABCDEF0;
      cyc();
      chk_out($sformatf("hold%0d", i),
              0, 1, 0, 0, 0, 0, 0);
    end
    prod_valid = 0; wb_start = 1;
    cyc();
    chk_out("hold_lo", 0, 1, 1, 32'h0, 0, 0, 0);
    wb_start = 0;
    cyc();
    chk_out("hold_hi", 0, 1, 1, 32'h1, 0, 0, 0);
    cyc();
    chk_out("hold_dn", 1, 0, 0, 0, 32'h1, 32'h0, 1);

    // random stimulus against the model
    clr = 1; prod_valid = 0; wb_start = 0;
    m_edge(1, 0, 0, '0);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 40) == 0);
      prod_valid = $urandom_range(0, 1);
      wb_start = ($urandom_range(0, 9) < 3);
      prod_data = {$urandom, $urandom};
      m_edge(clr, prod_valid, wb_start, prod_data);
      cyc();
      chk_out("rnd",
              !(m_have || m_q.size() > 0),
              m_have || m_q.size() > 0,
              m_q.size() > 0,
              (m_q.size() > 0) ? m_q[0] : '0,
              m_hi, m_lo, m_dn);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/mul_result_stage.md
MUL_RESULT_STAGE -- requirements
Module: mul_result_stage

Interface
REQ-001 SHALL have parameter: WORD_SIZE, default 32, datapath word width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: clr  input  1  synchronous active-high reset.
REQ-004 SHALL have port: prod_valid  input  1  upstream Booth multiplier product available.
REQ-005 SHALL have port: prod_ready  output  1  stage can accept a product.
REQ-006 SHALL have port: prod_data  input  2*WORD_SIZE  signed product, [2W-1:W]=high word, [W-1:0]=low word.
REQ-007 SHALL have port: wb_start  input  1  control-unit request to write the held product back.
REQ-008 SHALL have port: bus_out  output  WORD_SIZE  word driven onto CPU bus.
REQ-009 SHALL have port: bus_en  output  1  bus_out valid this cycle.
REQ-010 SHALL have port: hi_out  output  WORD_SIZE  architectural HI register.
REQ-011 SHALL have port: lo_out  output  WORD_SIZE  architectural LO register.
REQ-012 SHALL have port: busy  output  1  stage not in IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle pulse, write-back complete.

Function
REQ-014 SHALL implement FSM states IDLE, FULL, WR_LO, WR_HI.
REQ-015 SHALL drive prod_ready=1 only in IDLE; busy = (state != IDLE).
REQ-016 IDLE: on prod_valid=1 at an edge, SHALL latch prod_data into internal ZHI/ZLO and go to FULL; otherwise remain.
REQ-017 IDLE: wb_start SHALL be ignored; prod_valid and wb_start high together SHALL capture only, with no write-back started.
REQ-018 FULL: SHALL hold ZHI/ZLO unchanged, ignore prod_valid, and go to WR_LO at the first edge with wb_start=1.
REQ-019 WR_LO (exactly one cycle): bus_out=ZLO, bus_en=1; at the ending edge LO<=ZLO; next state WR_HI.
REQ-020 WR_HI (exactly one cycle): bus_out=ZHI, bus_en=1; at the ending edge HI<=ZHI; next state IDLE.
REQ-021 done SHALL be registered, high exactly during the first IDLE cycle after WR_HI, low otherwise.
REQ-022 Latency: wb_start sampled in FULL at edge N gives WR_LO in cycle N+1, WR_HI in N+2, done in N+3.
REQ-023 bus_out SHALL be all zeros and bus_en=0 in IDLE and FULL.
REQ-024 ZHI/ZLO, HI and LO SHALL store the raw bit pattern; no sign extension, negation or truncation.
REQ-025 HI/LO SHALL change only at the WR_HI/WR_LO edges; they hold their value across new captures.
REQ-026 A new capture SHALL be accepted in the IDLE cycle where done=1; back-to-back products are permitted.

Reset
REQ-027 clr=1 at an edge SHALL force state IDLE and clear ZHI, ZLO, HI, LO and done to 0, taking priority over all other inputs.
REQ-028 During reset and the following cycle: prod_ready=1, busy=0, bus_en=0, bus_out=0, hi_out=0, lo_out=0.
REQ-029 clr in WR_LO or WR_HI SHALL abort write-back: no done pulse, HI/LO cleared, including any LO already written.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, FULL, WR_LO, WR_HI) and the WORD_SIZE default constant.
REQ-031 ZHI, ZLO, HI, LO SHALL each be an instance of one sub-module reg_w.
REQ-032 reg_w SHALL be a WORD_SIZE-bit register with clk, synchronous clr and enable.
REQ-033 The FSM, bus mux and done flop SHALL reside in mul_result_stage.

Verification
REQ-034 Basic: reset; prod_data=0xFFFFFFFF_FFFFFFD6 (-6*7) with prod_valid; wb_start next cycle -> bus_out 0xFFFFFFD6 then 0xFFFFFFFF with bus_en=1; lo_out=0xFFFFFFD6, hi_out=0xFFFFFFFF; done one cycle.
REQ-035 Hold: capture 0x00000001_00000000, keep wb_start low 10 cycles, apply prod_valid with 0x12345678_9ABCDEF0 -> prod_ready=0, bus_en=0, later write-back yields hi_out=0x00000001, lo_out=0x00000000.
REQ-036 Simultaneous: prod_valid=1 and wb_start=1 in IDLE with 0x0000000A_0000000B -> state FULL, bus_en stays 0 until wb_start is reasserted.
REQ-037 Reset mid-op: clr asserted in WR_HI after a previous HI=0x5 write-back -> next cycle IDLE, hi_out=lo_out=0, done never pulses.
REQ-038 Back-to-back: capture a new product on the done cycle -> accepted (prod_ready=1); second write-back updates HI/LO with no lost cycle.
